vmm_result_uart: RTL and testbench

- Downstream stage of the matrix-multiply engine.
- Consumes one result element per `next` strobe (8-bit value plus its row/column indices) and buffers it in a small FIFO.
- Acknowledges the engine through `done_o`, which drives the engine's `done_i`.
- Serialises each element as two 8N1 UART bytes for board-level readback: an index byte {i[3:0], j[3:0]}, then the value byte.

---
 rtl/vmm_result_uart.sv | 170 +++++++++++++++++
 tb/tb_vmm_result_uart.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmm_result_uart.sv
// Result stage of the matrix-multiply engine: buffers {i,j,value} elements in a small
// FIFO, acknowledges each one, and streams them out as two 8N1 UART bytes.
module vmm_result_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDX_W        = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          next_i,
  input  logic [7:0]                    vmm_data_i,
  input  logic [IDX_W-1:0]              i_i,
  input  logic [IDX_W-1:0]              j_i,
  output logic                          done_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [15:0]       fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]  fifoCnt_q, fifoCnt_d;
  logic              armed_q, done_q, busy_q, busy_d;
  state_t            state_q;
  logic [BAUD_W-1:0] baudCnt_q;
  logic [2:0]        bitIdx_q;
  logic              byteSel_q;
  logic [15:0]       shift_q;
  logic              tx_q;

  logic       fifoFull, fifoEmpty, push, pop, lastTick, frameEnd;
  logic [7:0] curByte;

  // Only the low nibble of each index goes on the wire.
  if (IDX_W > 4) begin : g_idxHigh
    logic unusedIdxBits;
    assign unusedIdxBits = ^{i_i[IDX_W-1:4], j_i[IDX_W-1:4]};
  end

  assign fifoFull  = (fifoCnt_q == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty = (fifoCnt_q == '0);
  assign push      = next_i & armed_q & ~fifoFull;
  assign pop       = (state_q == IDLE) & ~fifoEmpty;
  assign lastTick  = (baudCnt_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign curByte   = byteSel_q ? shift_q[7:0] : shift_q[15:8];
  assign frameEnd  = (state_q == STOP) & lastTick & byteSel_q;

  always_comb begin
    fifoCnt_d = fifoCnt_q;
    if (push && !pop)
      fifoCnt_d = fifoCnt_q + CNT_W'(1);
    else if (pop && !push)
      fifoCnt_d = fifoCnt_q - CNT_W'(1);
  end

  // Busy is computed from next-state values so it stays high across the pop edge.
  assign busy_d = (fifoCnt_d != '0) | ~(((state_q == IDLE) & ~pop) | frameEnd);

  always_ff @(posedge clk) begin
    if (push)
      fifoMem_q[wrPtr_q] <= {i_i[3:0], j_i[3:0], vmm_data_i};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      fifoCnt_q <= '0;
    end else begin
      if (push)
        wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)
        rdPtr_q <= rdPtr_q + PTR_W'(1);
      fifoCnt_q <= fifoCnt_d;
    end
  end

  // Armed drops on accept and only re-arms once the engine lowers next_i.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      if (!next_i)
        armed_q <= 1'b1;
      else if (push)
        armed_q <= 1'b0;
      done_q <= push;
      busy_q <= busy_d;
    end
  end

  // tx_q is loaded with the level of the state being entered, so the line is glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      byteSel_q <= 1'b0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baudCnt_q <= '0;
          tx_q      <= 1'b1;
          if (pop) begin
            shift_q   <= fifoMem_q[rdPtr_q];
            byteSel_q <= 1'b0;
            state_q   <= START;
            tx_q      <= 1'b0;
          end
        end
        START: begin
          if (lastTick) begin
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            state_q   <= DATA;
            tx_q      <= curByte[0];
          end else begin
            baudCnt_q <= baudCnt_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (lastTick) begin
            baudCnt_q <= '0;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
              tx_q     <= curByte[bitIdx_q + 3'd1];
            end
          end else begin
            baudCnt_q <= baudCnt_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (lastTick) begin
            baudCnt_q <= '0;
            if (!byteSel_q) begin
              byteSel_q <= 1'b1;
              state_q   <= START;
              tx_q      <= 1'b0;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baudCnt_q <= baudCnt_q + BAUD_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done_o     = done_q;
  assign tx_o       = tx_q;
  assign busy_o     = busy_q;
  assign fifo_cnt_o = fifoCnt_q;

endmodule

// File: tb/tb_vmm_result_uart.sv
// Directed bench for vmm_result_uart: a UART receiver model pops expected bytes from a
// scoreboard queue filled as elements are presented.
module tb_vmm_result_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int IDXW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            next_i = 1'b0;
  logic [7:0]      vmm_data_i = '0;
  logic [IDXW-1:0] i_i = '0;
  logic [IDXW-1:0] j_i = '0;
  logic            done_o, tx_o, busy_o;
  logic [2:0]      fifo_cnt_o;

  int checks = 0, passed = 0, fails = 0;
  int cycleCnt = 0, doneCount = 0, busyCycles = 0, peakCnt = 0, acceptCycle = 0;
  bit abortFlag = 1'b0;
  logic [7:0] sb[$];

  vmm_result_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IDX_W(IDXW)) dut (
    .clk(clk), .rst(rst), .next_i(next_i), .vmm_data_i(vmm_data_i),
    .i_i(i_i), .j_i(j_i), .done_o(done_o), .tx_o(tx_o),
    .busy_o(busy_o), .fifo_cnt_o(fifo_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  always @(negedge clk) begin
    if (done_o === 1'b1) doneCount++;
    if (busy_o === 1'b1) busyCycles++;
    if (int'(fifo_cnt_o) > peakCnt) peakCnt = int'(fifo_cnt_o);
  end

  always @(posedge rst) abortFlag = 1'b1;

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sbPush(input logic [IDXW-1:0] ii, input logic [IDXW-1:0] jj, input logic [7:0] v);
    sb.push_back({ii[3:0], jj[3:0]});
    sb.push_back(v);
  endtask

  // Presents one element and holds next_i until acknowledged and holdCycles have elapsed.
  task automatic applyStimulus(input logic [IDXW-1:0] ii, input logic [IDXW-1:0] jj,
                               input logic [7:0] v, input int holdCycles, input int budget);
    int n = 0;
    bit got = 1'b0;
    @(negedge clk);
    i_i = ii; j_i = jj; vmm_data_i = v; next_i = 1'b1;
    sbPush(ii, jj, v);
    while ((!got || n < holdCycles) && n < budget) begin
      @(negedge clk);
      n++;
      if (!got && done_o === 1'b1) begin
        got = 1'b1;
        acceptCycle = cycleCnt;
      end
    end
    checkOutput("accept_seen", 32'(got), 32'd1);
    next_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy_o !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'(busy_o), 32'd0);
  endtask

  // Receiver model: samples each bit at its centre on the falling clock edge.
  initial begin : uartMonitor
    logic [7:0] rx;
    logic [7:0] expByte;
    logic       startBit, stopBit;
    forever begin
      @(negedge clk);
      if (tx_o === 1'b0 && rst === 1'b0) begin
        abortFlag = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        startBit = tx_o;
        for (int b = 0; b < 8; b++) begin
          repeat (CPB) @(negedge clk);
          rx[b] = tx_o;
        end
        repeat (CPB) @(negedge clk);
        stopBit = tx_o;
        if (!abortFlag) begin
          checkOutput("rx_start_bit", 32'(startBit), 32'd0);
          checkOutput("rx_stop_bit", 32'(stopBit), 32'd1);
          if (sb.size() == 0) begin
            checkOutput("rx_extra_byte", 32'(rx), 32'hFFFF_FFFF);
          end else begin
            expByte = sb.pop_front();
            checkOutput("rx_byte", 32'(rx), 32'(expByte));
          end
        end
      end
    end
  end

  initial begin : mainSeq
    int base, txLow, n;
    bit earlyDone;

    // Asynchronous reset takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_tx", 32'(tx_o), 32'd1);
    checkOutput("reset_done", 32'(done_o), 32'd0);
    checkOutput("reset_busy", 32'(busy_o), 32'd0);
    checkOutput("reset_cnt", 32'(fifo_cnt_o), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single element with accept/pop latency and total busy length.
    $display("[TB] single element");
    @(negedge clk);
    i_i = 5'd2; j_i = 5'd3; vmm_data_i = 8'h5A; next_i = 1'b1;
    sbPush(5'd2, 5'd3, 8'h5A);
    base = doneCount;
    busyCycles = 0;
    @(negedge clk);
    checkOutput("single_done_pulse", 32'(done_o), 32'd1);
    checkOutput("single_cnt_push", 32'(fifo_cnt_o), 32'd1);
    checkOutput("single_tx_before_pop", 32'(tx_o), 32'd1);
    checkOutput("single_busy_push", 32'(busy_o), 32'd1);
    @(negedge clk);
    checkOutput("single_done_end", 32'(done_o), 32'd0);
    checkOutput("single_tx_start", 32'(tx_o), 32'd0);
    checkOutput("single_cnt_pop", 32'(fifo_cnt_o), 32'd0);
    checkOutput("single_busy_pop", 32'(busy_o), 32'd1);
    repeat (8) @(negedge clk);
    next_i = 1'b0;
    checkOutput("single_done_count", 32'(doneCount - base), 32'd1);
    waitIdle(400);
    checkOutput("single_busy_len", 32'(busyCycles), 32'd81);
    checkOutput("single_sb_empty", 32'(sb.size()), 32'd0);

    // Long hold gives one push; re-raising gives another (high index bits ignored).
    $display("[TB] level hold");
    peakCnt = 0;
    base = doneCount;
    applyStimulus(5'd1, 5'd4, 8'hC3, 100, 200);
    checkOutput("hold_done_count", 32'(doneCount - base), 32'd1);
    checkOutput("hold_peak_cnt", 32'(peakCnt), 32'd1);
    applyStimulus(5'h15, 5'h16, 8'h81, 2, 200);
    checkOutput("rearm_done_count", 32'(doneCount - base), 32'd2);
    waitIdle(400);
    checkOutput("hold_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: one element in flight, four fill the FIFO, two more wait for pops.
    $display("[TB] backpressure");
    applyStimulus(5'd0, 5'd1, 8'h01, 1, 50);
    applyStimulus(5'd1, 5'd2, 8'h10, 1, 50);
    applyStimulus(5'd2, 5'd3, 8'h20, 1, 50);
    applyStimulus(5'd3, 5'd4, 8'h30, 1, 50);
    applyStimulus(5'd4, 5'd5, 8'h40, 1, 50);
    checkOutput("bp_cnt_full", 32'(fifo_cnt_o), 32'd4);
    @(negedge clk);
    i_i = 5'd5; j_i = 5'd6; vmm_data_i = 8'h50; next_i = 1'b1;
    sbPush(5'd5, 5'd6, 8'h50);
    earlyDone = 1'b0;
    n = 0;
    while (fifo_cnt_o !== 3'd3 && n < 300) begin
      @(negedge clk);
      n++;
      if (done_o === 1'b1) earlyDone = 1'b1;
    end
    checkOutput("bp_no_early_done", 32'(earlyDone), 32'd0);
    checkOutput("bp_pop_seen", 32'(fifo_cnt_o), 32'd3);
    @(negedge clk);
    checkOutput("bp_done_after_pop", 32'(done_o), 32'd1);
    checkOutput("bp_cnt_refill", 32'(fifo_cnt_o), 32'd4);
    next_i = 1'b0;
    @(negedge clk);
    applyStimulus(5'd6, 5'd7, 8'h60, 1, 300);
    waitIdle(1000);
    checkOutput("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Push lands on the IDLE pop edge with one entry queued.
    $display("[TB] simultaneous push/pop");
    applyStimulus(5'd2, 5'd2, 8'h71, 1, 50);
    base = acceptCycle;
    applyStimulus(5'd3, 5'd3, 8'h72, 1, 50);
    while (cycleCnt < base + 81) @(negedge clk);
    checkOutput("simul_cnt_before", 32'(fifo_cnt_o), 32'd1);
    i_i = 5'd4; j_i = 5'd4; vmm_data_i = 8'h73; next_i = 1'b1;
    sbPush(5'd4, 5'd4, 8'h73);
    @(negedge clk);
    checkOutput("simul_cnt_same", 32'(fifo_cnt_o), 32'd1);
    checkOutput("simul_done", 32'(done_o), 32'd1);
    next_i = 1'b0;
    @(negedge clk);
    checkOutput("simul_cnt_after", 32'(fifo_cnt_o), 32'd1);
    waitIdle(600);
    checkOutput("simul_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during the value byte's data bits, with a second entry queued.
    $display("[TB] reset mid-frame");
    applyStimulus(5'd7, 5'd8, 8'h18, 1, 50);
    base = acceptCycle;
    applyStimulus(5'd9, 5'd10, 8'h99, 1, 50);
    while (cycleCnt < base + 55) @(negedge clk);
    checkOutput("pre_reset_tx_low", 32'(tx_o), 32'd0);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset_tx", 32'(tx_o), 32'd1);
    checkOutput("midreset_cnt", 32'(fifo_cnt_o), 32'd0);
    checkOutput("midreset_busy", 32'(busy_o), 32'd0);
    checkOutput("midreset_done", 32'(done_o), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txLow = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_o === 1'b0) txLow++;
    end
    checkOutput("post_reset_line_idle", 32'(txLow), 32'd0);
    checkOutput("post_reset_busy", 32'(busy_o), 32'd0);
    checkOutput("post_reset_cnt", 32'(fifo_cnt_o), 32'd0);
    applyStimulus(5'd1, 5'd1, 8'h0F, 1, 50);
    waitIdle(400);
    checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
